// File: rtl/punc_control_fsm_pkg.sv
// Shared PUnC control/datapath definitions: states, opcodes, select encodings
// and the packed control word driven to the datapath.
package punc_control_fsm_pkg;

  localparam int unsigned W_IR      = 16;
  localparam int unsigned W_OPCODE  = 4;
  localparam int unsigned W_NZP     = 3;
  localparam int unsigned W_SET_PC  = 3;
  localparam int unsigned W_ALU     = 3;
  localparam int unsigned W_MEM_R   = 3;
  localparam int unsigned W_MEM_W   = 2;
  localparam int unsigned W_MEM_WD  = 1;
  localparam int unsigned W_RF_SEL  = 2;

  typedef enum logic [2:0] {
    ST_FETCH    = 3'd0,
    ST_DECODE   = 3'd1,
    ST_EXECUTE  = 3'd2,
    ST_EXECUTE2 = 3'd3,
    ST_HALT     = 3'd4
  } state_t;

  localparam logic [W_OPCODE-1:0] OP_BR   = 4'b0000;
  localparam logic [W_OPCODE-1:0] OP_ADD  = 4'b0001;
  localparam logic [W_OPCODE-1:0] OP_LD   = 4'b0010;
  localparam logic [W_OPCODE-1:0] OP_ST   = 4'b0011;
  localparam logic [W_OPCODE-1:0] OP_JSR  = 4'b0100;
  localparam logic [W_OPCODE-1:0] OP_AND  = 4'b0101;
  localparam logic [W_OPCODE-1:0] OP_LDR  = 4'b0110;
  localparam logic [W_OPCODE-1:0] OP_STR  = 4'b0111;
  localparam logic [W_OPCODE-1:0] OP_RTI  = 4'b1000;
  localparam logic [W_OPCODE-1:0] OP_NOT  = 4'b1001;
  localparam logic [W_OPCODE-1:0] OP_LDI  = 4'b1010;
  localparam logic [W_OPCODE-1:0] OP_STI  = 4'b1011;
  localparam logic [W_OPCODE-1:0] OP_JMP  = 4'b1100;
  localparam logic [W_OPCODE-1:0] OP_RSV  = 4'b1101;
  localparam logic [W_OPCODE-1:0] OP_LEA  = 4'b1110;
  localparam logic [W_OPCODE-1:0] OP_TRAP = 4'b1111;

  localparam logic [W_SET_PC-1:0] PC_HOLD      = 3'd0;
  localparam logic [W_SET_PC-1:0] PC_OFFSET9   = 3'd1;
  localparam logic [W_SET_PC-1:0] PC_OFFSET11  = 3'd2;
  localparam logic [W_SET_PC-1:0] PC_RF_R_DATA = 3'd3;

  localparam logic [W_MEM_R-1:0] MEM_R_ADDR_NONE    = 3'd0;
  localparam logic [W_MEM_R-1:0] MEM_R_ADDR_SEL_PC  = 3'd1;
  localparam logic [W_MEM_R-1:0] MEM_R_ADDR_SEL_MEM = 3'd2;
  localparam logic [W_MEM_R-1:0] MEM_R_ADDR_SEL_RF  = 3'd3;
  localparam logic [W_MEM_R-1:0] MEM_R_ADDR_FETCH   = 3'd4;

  localparam logic [W_ALU-1:0] ALU_NONE = 3'd0;
  localparam logic [W_ALU-1:0] ALU_ADD1 = 3'd1;
  localparam logic [W_ALU-1:0] ALU_ADD2 = 3'd2;
  localparam logic [W_ALU-1:0] ALU_AND1 = 3'd3;
  localparam logic [W_ALU-1:0] ALU_AND2 = 3'd4;
  localparam logic [W_ALU-1:0] ALU_PC   = 3'd5;
  localparam logic [W_ALU-1:0] ALU_NOT  = 3'd6;

  localparam logic [W_MEM_W-1:0] MEM_W_ADDR_NONE    = 2'd0;
  localparam logic [W_MEM_W-1:0] MEM_W_ADDR_SEL_PC  = 2'd1;
  localparam logic [W_MEM_W-1:0] MEM_W_ADDR_SEL_MEM = 2'd2;
  localparam logic [W_MEM_W-1:0] MEM_W_ADDR_SEL_RF  = 2'd3;

  localparam logic [W_MEM_WD-1:0] MEM_W_DATA_NONE = 1'b0;
  localparam logic [W_MEM_WD-1:0] MEM_W_DATA_RF   = 1'b1;

  localparam logic [W_RF_SEL-1:0] RF_R0_NONE    = 2'd0;
  localparam logic [W_RF_SEL-1:0] RF_R0_SEL_86  = 2'd1;
  localparam logic [W_RF_SEL-1:0] RF_R0_SEL_119 = 2'd2;

  localparam logic [W_RF_SEL-1:0] RF_R1_NONE    = 2'd0;
  localparam logic [W_RF_SEL-1:0] RF_R1_SEL_20  = 2'd1;
  localparam logic [W_RF_SEL-1:0] RF_R1_SEL_86  = 2'd2;

  localparam logic [W_RF_SEL-1:0] RF_W_ADDR_NONE    = 2'd0;
  localparam logic [W_RF_SEL-1:0] RF_W_ADDR_SEL_119 = 2'd1;
  localparam logic [W_RF_SEL-1:0] RF_W_ADDR_SEL_7   = 2'd2;

  localparam logic [W_RF_SEL-1:0] RF_W_DATA_NONE = 2'd0;
  localparam logic [W_RF_SEL-1:0] RF_W_DATA_ALU  = 2'd1;
  localparam logic [W_RF_SEL-1:0] RF_W_DATA_MEM  = 2'd2;
  localparam logic [W_RF_SEL-1:0] RF_W_DATA_PC   = 2'd3;

  localparam logic [W_NZP-1:0] COND_NEG  = 3'b100;
  localparam logic [W_NZP-1:0] COND_ZERO = 3'b010;
  localparam logic [W_NZP-1:0] COND_POS  = 3'b001;

  typedef struct packed {
    logic                load_ir;
    logic                inc_pc;
    logic [W_SET_PC-1:0] set_pc;
    logic [W_ALU-1:0]    alu_select;
    logic                mem_w_en;
    logic [W_MEM_R-1:0]  set_mem_r_addr;
    logic [W_MEM_W-1:0]  set_mem_w_addr;
    logic [W_MEM_WD-1:0] set_mem_w_data;
    logic                rf_w_en;
    logic [W_RF_SEL-1:0] set_rf_r_addr0;
    logic [W_RF_SEL-1:0] set_rf_r_addr1;
    logic [W_RF_SEL-1:0] set_rf_w_addr;
    logic [W_RF_SEL-1:0] set_rf_w_data;
    logic                nzp_we;
  } ctrl_t;

endpackage

// File: rtl/punc_control_fsm_decode.sv
// Combinational opcode-to-control-word decoder for the EXECUTE/EXECUTE2 phases.
module punc_decode
  import punc_control_fsm_pkg::*;
(
  input  logic [W_IR-1:0]  ir,
  input  logic [W_NZP-1:0] nzp,
  input  logic             exec2,
  output ctrl_t            ctrl
);

  logic [W_OPCODE-1:0] opcode;
  logic                unused_ir_bits;

  assign opcode         = ir[15:12];
  assign unused_ir_bits = ^{ir[8:6], ir[4:0]};

  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_ADD, OP_AND: begin
        ctrl.set_rf_r_addr0 = RF_R0_SEL_86;
        ctrl.set_rf_w_addr  = RF_W_ADDR_SEL_119;
        ctrl.set_rf_w_data  = RF_W_DATA_ALU;
        ctrl.rf_w_en        = 1'b1;
        ctrl.nzp_we         = 1'b1;
        if (ir[5]) begin
          ctrl.alu_select = (opcode == OP_ADD) ? ALU_ADD2 : ALU_AND2;
        end else begin
          ctrl.alu_select     = (opcode == OP_ADD) ? ALU_ADD1 : ALU_AND1;
          ctrl.set_rf_r_addr1 = RF_R1_SEL_20;
        end
      end
      OP_NOT: begin
        ctrl.set_rf_r_addr0 = RF_R0_SEL_86;
        ctrl.set_rf_w_addr  = RF_W_ADDR_SEL_119;
        ctrl.set_rf_w_data  = RF_W_DATA_ALU;
        ctrl.alu_select     = ALU_NOT;
        ctrl.rf_w_en        = 1'b1;
        ctrl.nzp_we         = 1'b1;
      end
      OP_LEA: begin
        ctrl.alu_select    = ALU_PC;
        ctrl.set_rf_w_data = RF_W_DATA_ALU;
        ctrl.set_rf_w_addr = RF_W_ADDR_SEL_119;
        ctrl.rf_w_en       = 1'b1;
        ctrl.nzp_we        = 1'b1;
      end
      OP_LD, OP_LDR: begin
        ctrl.set_mem_r_addr = (opcode == OP_LD) ? MEM_R_ADDR_SEL_PC : MEM_R_ADDR_SEL_RF;
        if (opcode == OP_LDR) ctrl.set_rf_r_addr0 = RF_R0_SEL_86;
        ctrl.set_rf_w_data  = RF_W_DATA_MEM;
        ctrl.set_rf_w_addr  = RF_W_ADDR_SEL_119;
        ctrl.rf_w_en        = 1'b1;
        ctrl.nzp_we         = 1'b1;
      end
      // Indirect load: first phase fetches the pointer, second reads through it.
      OP_LDI: begin
        if (!exec2) begin
          ctrl.set_mem_r_addr = MEM_R_ADDR_SEL_PC;
        end else begin
          ctrl.set_mem_r_addr = MEM_R_ADDR_SEL_MEM;
          ctrl.set_rf_w_data  = RF_W_DATA_MEM;
          ctrl.set_rf_w_addr  = RF_W_ADDR_SEL_119;
          ctrl.rf_w_en        = 1'b1;
          ctrl.nzp_we         = 1'b1;
        end
      end
      OP_ST: begin
        ctrl.set_rf_r_addr0 = RF_R0_SEL_119;
        ctrl.set_mem_w_addr = MEM_W_ADDR_SEL_PC;
        ctrl.mem_w_en       = 1'b1;
      end
      OP_STR: begin
        ctrl.set_rf_r_addr0 = RF_R0_SEL_119;
        ctrl.set_rf_r_addr1 = RF_R1_SEL_86;
        ctrl.set_mem_w_addr = MEM_W_ADDR_SEL_RF;
        ctrl.mem_w_en       = 1'b1;
      end
      OP_STI: begin
        ctrl.set_mem_r_addr = MEM_R_ADDR_SEL_PC;
        if (exec2) begin
          ctrl.set_rf_r_addr0 = RF_R0_SEL_119;
          ctrl.set_mem_w_addr = MEM_W_ADDR_SEL_MEM;
          ctrl.mem_w_en       = 1'b1;
        end
      end
      // R7 link write and PC jump commit together, both from pre-jump values.
      OP_JSR: begin
        ctrl.set_rf_w_addr = RF_W_ADDR_SEL_7;
        ctrl.set_rf_w_data = RF_W_DATA_PC;
        ctrl.rf_w_en       = 1'b1;
        if (ir[11]) begin
          ctrl.set_pc = PC_OFFSET11;
        end else begin
          ctrl.set_rf_r_addr0 = RF_R0_SEL_86;
          ctrl.set_pc         = PC_RF_R_DATA;
        end
      end
      OP_JMP: begin
        ctrl.set_rf_r_addr0 = RF_R0_SEL_86;
        ctrl.set_pc         = PC_RF_R_DATA;
      end
      OP_BR: begin
        if ((ir[11:9] & nzp) != 3'b000) ctrl.set_pc = PC_OFFSET9;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/punc_control_fsm.sv
// PUnC LC3 control unit: FETCH/DECODE/EXECUTE sequencer and NZP register.
// Build option PUNC_ILLEGAL_OP_HALT_EN sends RTI/reserved opcodes to HALT.
module punc_control_fsm
  import punc_control_fsm_pkg::*;
#(
  parameter logic [W_NZP-1:0]    RESET_NZP   = 3'b010,
  parameter logic [W_OPCODE-1:0] HALT_OPCODE = 4'hF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [W_IR-1:0]     ir,
  input  logic [W_NZP-1:0]    cond_code,
  output logic                load_ir,
  output logic                inc_pc,
  output logic [W_SET_PC-1:0] set_pc,
  output logic [W_ALU-1:0]    alu_select,
  output logic                mem_w_en,
  output logic [W_MEM_R-1:0]  set_mem_r_addr,
  output logic [W_MEM_W-1:0]  set_mem_w_addr,
  output logic [W_MEM_WD-1:0] set_mem_w_data,
  output logic                rf_w_en,
  output logic [W_RF_SEL-1:0] set_rf_r_addr0,
  output logic [W_RF_SEL-1:0] set_rf_r_addr1,
  output logic [W_RF_SEL-1:0] set_rf_w_addr,
  output logic [W_RF_SEL-1:0] set_rf_w_data,
  output logic [W_NZP-1:0]    nzp,
  output logic                halted
);

  state_t              state_q, state_d;
  logic [W_NZP-1:0]    nzp_q;
  logic [W_OPCODE-1:0] opcode;
  logic                halt_op;
  logic                two_phase_op;
  ctrl_t               dec_ctrl;
  ctrl_t               ctrl;

  assign opcode       = ir[15:12];
  assign two_phase_op = (opcode == OP_LDI) || (opcode == OP_STI);
`ifdef PUNC_ILLEGAL_OP_HALT_EN
  assign halt_op = (opcode == HALT_OPCODE) || (opcode == OP_RTI) || (opcode == OP_RSV);
`else
  assign halt_op = (opcode == HALT_OPCODE);
`endif

  punc_decode u_decode (
    .ir    (ir),
    .nzp   (nzp_q),
    .exec2 (state_q == ST_EXECUTE2),
    .ctrl  (dec_ctrl)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      nzp_q   <= RESET_NZP;
    end else begin
      state_q <= state_d;
      if (ctrl.nzp_we) nzp_q <= cond_code;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:    state_d = ST_DECODE;
      ST_DECODE:   state_d = halt_op ? ST_HALT : ST_EXECUTE;
      ST_EXECUTE:  state_d = two_phase_op ? ST_EXECUTE2 : ST_FETCH;
      ST_EXECUTE2: state_d = ST_FETCH;
      ST_HALT:     state_d = ST_HALT;
      default:     state_d = ST_FETCH;
    endcase
  end

  // Reset forces every strobe idle in the same cycle, even mid-instruction.
  always_comb begin
    ctrl = '0;
    case (state_q)
      ST_FETCH: begin
        ctrl.load_ir        = 1'b1;
        ctrl.set_mem_r_addr = MEM_R_ADDR_FETCH;
      end
      ST_DECODE:               ctrl.inc_pc = 1'b1;
      ST_EXECUTE, ST_EXECUTE2: ctrl = dec_ctrl;
      default:                 ctrl = '0;
    endcase
    if (rst) ctrl = '0;
  end

  assign load_ir        = ctrl.load_ir;
  assign inc_pc         = ctrl.inc_pc;
  assign set_pc         = ctrl.set_pc;
  assign alu_select     = ctrl.alu_select;
  assign mem_w_en       = ctrl.mem_w_en;
  assign set_mem_r_addr = ctrl.set_mem_r_addr;
  assign set_mem_w_addr = ctrl.set_mem_w_addr;
  assign set_mem_w_data = ctrl.set_mem_w_data;
  assign rf_w_en        = ctrl.rf_w_en;
  assign set_rf_r_addr0 = ctrl.set_rf_r_addr0;
  assign set_rf_r_addr1 = ctrl.set_rf_r_addr1;
  assign set_rf_w_addr  = ctrl.set_rf_w_addr;
  assign set_rf_w_data  = ctrl.set_rf_w_data;
  assign nzp            = nzp_q;
  assign halted         = (state_q == ST_HALT) && !rst;

endmodule

// File: tb/tb_punc_control_fsm.sv
// Directed scoreboard bench for punc_control_fsm; expected control words are
// queued as each cycle's stimulus is driven and checked against the DUT.
module tb_punc_control_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ir = 16'h0000;
  logic [2:0]  cond_code = 3'b000;
  logic        load_ir, inc_pc, mem_w_en, rf_w_en, halted;
  logic [2:0]  set_pc, alu_select, set_mem_r_addr, nzp;
  logic [1:0]  set_mem_w_addr, set_rf_r_addr0, set_rf_r_addr1, set_rf_w_addr, set_rf_w_data;
  logic        set_mem_w_data;

  int checks = 0;
  int failures = 0;
  logic [2:0] nzp_m = 3'b010;

  typedef struct {
    string       tag;
    logic [24:0] c;
    logic [2:0]  n;
  } sb_t;
  sb_t sb[$];

  punc_control_fsm dut (
    .clk(clk), .rst(rst), .ir(ir), .cond_code(cond_code),
    .load_ir(load_ir), .inc_pc(inc_pc), .set_pc(set_pc), .alu_select(alu_select),
    .mem_w_en(mem_w_en), .set_mem_r_addr(set_mem_r_addr), .set_mem_w_addr(set_mem_w_addr),
    .set_mem_w_data(set_mem_w_data), .rf_w_en(rf_w_en), .set_rf_r_addr0(set_rf_r_addr0),
    .set_rf_r_addr1(set_rf_r_addr1), .set_rf_w_addr(set_rf_w_addr),
    .set_rf_w_data(set_rf_w_data), .nzp(nzp), .halted(halted)
  );

  always #5 clk = ~clk;

  // Control word: {load_ir,inc_pc,set_pc,alu,mem_w_en,mem_r,mem_w_addr,mem_w_data,rf_w_en,r0,r1,wa,wd,halted}
  function automatic logic [24:0] ex(input logic li = 1'b0, input logic ip = 1'b0,
                                     input logic [2:0] pc = 3'd0, input logic [2:0] alu = 3'd0,
                                     input logic mwe = 1'b0, input logic [2:0] mra = 3'd0,
                                     input logic [1:0] mwa = 2'd0, input logic rwe = 1'b0,
                                     input logic [1:0] r0 = 2'd0, input logic [1:0] r1 = 2'd0,
                                     input logic [1:0] wa = 2'd0, input logic [1:0] wd = 2'd0,
                                     input logic h = 1'b0);
    return {li, ip, pc, alu, mwe, mra, mwa, 1'b0, rwe, r0, r1, wa, wd, h};
  endfunction

  task automatic cyc(input string tag, input logic [15:0] ir_v, input logic [2:0] cc_v,
                     input logic rst_v, input logic upd, input logic [24:0] exp_c);
    sb_t e;
    logic [24:0] obs;
    @(negedge clk);
    ir = ir_v;
    cond_code = cc_v;
    rst = rst_v;
    sb.push_back('{tag, exp_c, nzp_m});
    #1;
    e = sb.pop_front();
    obs = {load_ir, inc_pc, set_pc, alu_select, mem_w_en, set_mem_r_addr, set_mem_w_addr,
           set_mem_w_data, rf_w_en, set_rf_r_addr0, set_rf_r_addr1, set_rf_w_addr,
           set_rf_w_data, halted};
    checks++;
    assert (obs === e.c) else begin
      failures++;
      $error("FAIL %s ctrl observed=%h expected=%h", e.tag, obs, e.c);
    end
    checks++;
    assert (nzp === e.n) else begin
      failures++;
      $error("FAIL %s nzp observed=%b expected=%b", e.tag, nzp, e.n);
    end
    if (rst_v) nzp_m = 3'b010;
    else if (upd) nzp_m = cc_v;
  endtask

  task automatic fd(input string tag, input logic [15:0] ir_v);
    cyc({tag, "_fetch"}, ir_v, 3'b000, 1'b0, 1'b0, ex(.li(1'b1), .mra(3'd4)));
    cyc({tag, "_decode"}, ir_v, 3'b000, 1'b0, 1'b0, ex(.ip(1'b1)));
  endtask

  initial begin
    cyc("reset", 16'h0000, 3'b000, 1'b1, 1'b0, ex());

    fd("add_imm", 16'h1261);
    cyc("add_imm_exec", 16'h1261, 3'b001, 1'b0, 1'b1,
        ex(.alu(3'd2), .rwe(1'b1), .r0(2'd1), .wa(2'd1), .wd(2'd1)));

    fd("and_imm", 16'h5260);
    cyc("and_imm_exec", 16'h5260, 3'b010, 1'b0, 1'b1,
        ex(.alu(3'd4), .rwe(1'b1), .r0(2'd1), .wa(2'd1), .wd(2'd1)));

    fd("brz", 16'h0405);
    cyc("brz_exec", 16'h0405, 3'b111, 1'b0, 1'b0, ex(.pc(3'd1)));
    fd("brn", 16'h0805);
    cyc("brn_exec", 16'h0805, 3'b111, 1'b0, 1'b0, ex());

    fd("add_reg", 16'h1042);
    cyc("add_reg_exec", 16'h1042, 3'b100, 1'b0, 1'b1,
        ex(.alu(3'd1), .rwe(1'b1), .r0(2'd1), .r1(2'd1), .wa(2'd1), .wd(2'd1)));

    fd("jsr", 16'h4802);
    cyc("jsr_exec", 16'h4802, 3'b001, 1'b0, 1'b0,
        ex(.pc(3'd2), .rwe(1'b1), .wa(2'd2), .wd(2'd3)));

    fd("st", 16'h3201);
    cyc("st_exec", 16'h3201, 3'b001, 1'b0, 1'b0,
        ex(.mwe(1'b1), .mwa(2'd1), .r0(2'd2)));

    fd("ldi", 16'hA403);
    cyc("ldi_exec", 16'hA403, 3'b001, 1'b0, 1'b0, ex(.mra(3'd1)));
    cyc("ldi_exec2", 16'hA403, 3'b001, 1'b0, 1'b1,
        ex(.mra(3'd2), .rwe(1'b1), .wa(2'd1), .wd(2'd2)));

    fd("not", 16'h967F);
    cyc("not_exec", 16'h967F, 3'b010, 1'b0, 1'b1,
        ex(.alu(3'd6), .rwe(1'b1), .r0(2'd1), .wa(2'd1), .wd(2'd1)));

    fd("sti", 16'hB601);
    cyc("sti_exec", 16'hB601, 3'b100, 1'b0, 1'b0, ex(.mra(3'd1)));
    cyc("sti_exec2", 16'hB601, 3'b100, 1'b0, 1'b0,
        ex(.mwe(1'b1), .mra(3'd1), .mwa(2'd2), .r0(2'd2)));

    fd("rti", 16'h8000);
`ifdef PUNC_ILLEGAL_OP_HALT_EN
    cyc("rti_halt", 16'h8000, 3'b001, 1'b0, 1'b0, ex(.h(1'b1)));
    cyc("rti_rst", 16'h8000, 3'b001, 1'b1, 1'b0, ex());
`else
    cyc("rti_nop", 16'h8000, 3'b001, 1'b0, 1'b0, ex());
`endif

    fd("sti_rst", 16'hB601);
    cyc("sti_rst_exec", 16'hB601, 3'b100, 1'b0, 1'b0, ex(.mra(3'd1)));
    cyc("sti_rst_exec2", 16'hB601, 3'b100, 1'b1, 1'b0, ex());
    cyc("post_rst_fetch", 16'hB601, 3'b100, 1'b0, 1'b0, ex(.li(1'b1), .mra(3'd4)));
    cyc("post_rst_decode", 16'h1261, 3'b100, 1'b0, 1'b0, ex(.ip(1'b1)));
    cyc("post_rst_exec", 16'h1261, 3'b100, 1'b0, 1'b1,
        ex(.alu(3'd2), .rwe(1'b1), .r0(2'd1), .wa(2'd1), .wd(2'd1)));

    fd("trap", 16'hF025);
    for (int i = 0; i < 20; i++)
      cyc("trap_halt", 16'h1261, 3'b111, 1'b0, 1'b0, ex(.h(1'b1)));
    cyc("halt_rst", 16'h1261, 3'b111, 1'b1, 1'b0, ex());
    cyc("halt_rst_fetch", 16'h1261, 3'b111, 1'b0, 1'b0, ex(.li(1'b1), .mra(3'd4)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/punc_control_fsm.md
Name: punc_control_fsm

Overview:
Control unit for the PUnC LC3 processor, directly upstream of the PUnC datapath. Sequences each instruction through fetch, decode and execute states. Drives every datapath select, enable and strobe from the latched IR. Keeps the architectural NZP condition register.

Parameters:
RESET_NZP, 3'b010, NZP value loaded on reset (Z set).
HALT_OPCODE, 4'hF, opcode (TRAP) that enters HALT.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
ir  in  16  current instruction register from datapath (opcode output)
cond_code  in  3  datapath NZP of current rf_w_data {N,Z,P}
load_ir  out  1  latch mem_r_data into IR at next edge
inc_pc  out  1  PC <= PC+1 at next edge
set_pc  out  3  PC update select
alu_select  out  3  ALU operation
mem_w_en  out  1  memory write strobe
set_mem_r_addr  out  3  memory read-address select
set_mem_w_addr  out  2  memory write-address select
set_mem_w_data  out  1  memory write-data select
rf_w_en  out  1  register-file write strobe
set_rf_r_addr0  out  2  RF read port 0 select
set_rf_r_addr1  out  2  RF read port 1 select
set_rf_w_addr  out  2  RF write-address select
set_rf_w_data  out  2  RF write-data select
nzp  out  3  architectural condition register
halted  out  1  high while in HALT

Behaviour:
- Reset (sync, active-high, overrides everything, including mid-EXECUTE2): state=FETCH, nzp=RESET_NZP, halted=0.
- Idle value for every strobe is 0. Every select is at its package NONE/HOLD encoding (value 0) unless listed below. Outputs are Moore/combinational on state and ir.
- States: FETCH -> DECODE -> EXECUTE -> (EXECUTE2 | FETCH); HALT.
- FETCH: set_mem_r_addr=FETCH, load_ir=1.
- DECODE: inc_pc=1 (PC now points past the instruction). If ir[15:12]==HALT_OPCODE, go to HALT; otherwise go to EXECUTE.
- EXECUTE, per ir[15:12]:
  - ADD (0001) / AND (0101): r_addr0=SEL_86, rf_w_addr=SEL_119, rf_w_data=ALU, rf_w_en=1. If ir[5]=1, alu=ADD2/AND2; otherwise alu=ADD1/AND1 with r_addr1=SEL_20.
  - NOT (1001): as ADD with alu=NOT.
  - LEA (1110): alu=PC, w_data=ALU, w_addr=SEL_119, rf_w_en=1.
  - LD (0010): mem_r_addr=SEL_PC, w_data=MEM, w_addr=SEL_119, rf_w_en=1.
  - LDR (0110): as LD with mem_r_addr=SEL_RF and r_addr0=SEL_86.
  - LDI (1010): mem_r_addr=SEL_PC, no write. Then EXECUTE2: mem_r_addr=SEL_MEM, w_data=MEM, w_addr=SEL_119, rf_w_en=1.
  - ST (0011): r_addr0=SEL_119, mem_w_addr=SEL_PC, mem_w_en=1.
  - STR (0111): r_addr0=SEL_119, r_addr1=SEL_86, mem_w_addr=SEL_RF, mem_w_en=1.
  - STI (1011): mem_r_addr=SEL_PC. Then EXECUTE2: r_addr0=SEL_119, mem_w_addr=SEL_MEM, mem_r_addr=SEL_PC held, mem_w_en=1.
  - JSR/JSRR (0100): w_addr=SEL_7, w_data=PC, rf_w_en=1. If ir[11]=1, set_pc=OFFSET11; otherwise r_addr0=SEL_86, set_pc=RF_R_DATA. The R7 write and PC update commit on the same edge, both from old values.
  - JMP/RET (1100): r_addr0=SEL_86, set_pc=RF_R_DATA.
  - BR (0000): if (ir[11:9] & nzp) != 0, set_pc=OFFSET9; otherwise nothing.
  - RTI (1000) / reserved (1101): NOP.
- nzp update: nzp <= cond_code on the edge where rf_w_en=1 and the opcode is ADD, AND, NOT, LD, LDI, LDR or LEA. JSR/JSRR never update nzp.
- Latency: 3 cycles per instruction; LDI and STI take 4. BR uses nzp as it stood before the branch.
- HALT: halted=1, all strobes 0, held until rst.

Optional Feature:
PUNC_ILLEGAL_OP_HALT_EN.
- Defined: opcodes 1000 and 1101 go DECODE -> HALT, same as TRAP.
- Undefined: they execute as 3-cycle NOPs.

Decomposition:
- Shared package holds:
  - state encoding (FETCH=0, DECODE=1, EXECUTE=2, EXECUTE2=3, HALT=4);
  - opcode constants;
  - every select encoding (PC_HOLD=0, PC_OFFSET9=1, PC_OFFSET11=2, PC_RF_R_DATA=3; MEM_R_ADDR_NONE=0, SEL_PC=1, SEL_MEM=2, SEL_RF=3, FETCH=4; ALU_NONE=0, ADD1..NOT=1..6; remaining selects as NONE=0 then listed order);
  - COND_NEG=3'b100, COND_ZERO=3'b010, COND_POS=3'b001.
- The datapath uses the same package.
- One natural sub-module: punc_decode, a combinational opcode-to-control-word decoder used in EXECUTE/EXECUTE2.

Test Plan:
- Reset, ir=16'h1261 (ADD R1,R1,#1) -> cycle 0 load_ir=1; cycle 1 inc_pc=1; cycle 2 rf_w_en=1, alu=ADD2, w_addr=SEL_119; with cond_code=001, nzp=001 after.
- nzp=010, ir=16'h0405 (BRz) -> set_pc=OFFSET9 in EXECUTE. ir=16'h0805 (BRn) -> set_pc=HOLD.
- ir=16'hA403 (LDI R2) -> 4-cycle sequence: SEL_PC read, then SEL_MEM read with rf_w_en=1; next cycle is FETCH.
- nzp=100, ir=16'h4802 (JSR) with cond_code=001 -> rf_w_en=1, w_addr=SEL_7, set_pc=OFFSET11; nzp stays 100.
- ir=16'hF025 (TRAP) -> halted=1 from cycle 2 onward, all strobes 0 for 20 cycles. rst -> FETCH, nzp=010.
- rst asserted during EXECUTE2 of STI (16'hB601) -> mem_w_en=0 that cycle; next cycle FETCH.
